// File: rtl/encoder4to2_rr.sv
// encoder4to2_rr: registered 4:2 encoder with round-robin (or fixed) priority and a
// valid/ready output handshake. A captured index is held on {a_o,b_o} until downstream
// accepts it; multi-hot captures are flagged and completed handshakes are counted.
//
// Ports:
//   clk_i           sole clock, rising edge
//   rst_ni          synchronous active-low reset
//   en_i            capture enable
//   in0_i..in3_i    level-sensitive request lines
//   ready_i         downstream accept
//   a_o, b_o        encoded index of the selected request (a_o is MSB)
//   valid_o         {a_o,b_o} and multi_o are valid
//   multi_o         two or more requests were high at the capturing edge
//   cnt_o           completed handshakes, wraps modulo 2^CNT_W
module encoder4to2_rr #(
  parameter int unsigned ROTATE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             in0_i,
  input  logic             in1_i,
  input  logic             in2_i,
  input  logic             in3_i,
  input  logic             ready_i,
  output logic             a_o,
  output logic             b_o,
  output logic             valid_o,
  output logic             multi_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         idx_q, idx_d;
  logic               multi_q, multi_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0] req;
  logic [1:0] win;
  logic [1:0] probe;
  logic       found;
  logic       multi_w;
  logic       capture;

  assign req = {in3_i, in2_i, in1_i, in0_i};

  // Search from ptr_q upward (mod 4); the first asserted line wins.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    probe = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      probe = ptr_q + 2'(i);
      if (!found && req[probe]) begin
        win   = probe;
        found = 1'b1;
      end
    end
  end

  assign multi_w = (3'(in0_i) + 3'(in1_i) + 3'(in2_i) + 3'(in3_i)) >= 3'd2;
  assign capture = en_i & (|req);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    multi_d = multi_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StHold;
          idx_d   = win;
          multi_d = multi_w;
          ptr_d   = (ROTATE != 0) ? win + 2'd1 : 2'd0;
        end
      end
      StHold: begin
        // Inputs are ignored until downstream accepts the held result.
        if (ready_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (capture) begin
            idx_d   = win;
            multi_d = multi_w;
            ptr_d   = (ROTATE != 0) ? win + 2'd1 : 2'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      multi_q <= multi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = (state_q == StHold);
  assign a_o     = idx_q[1];
  assign b_o     = idx_q[0];
  assign multi_o = multi_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_encoder4to2_rr.sv
// Bench for encoder4to2_rr. Three instances share request/enable/reset lines but have
// private ready inputs: u_rr (round-robin, 8-bit count), u_fx (fixed priority) and
// u_wr (round-robin, 2-bit count). Expected transfers are queued per instance and
// popped by a negedge monitor whenever that instance presents valid&ready.
module tb_encoder4to2_rr;

  logic clk = 1'b0;
  logic rst_n, en, in0, in1, in2, in3;
  logic rdy0, rdy1, rdy2;

  logic a0, b0, v0, m0;
  logic a1, b1, v1, m1;
  logic a2, b2, v2, m2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  int errors = 0;
  int checks = 0;

  // Entries are {a,b,multi}.
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] q2[$];

  always #5 clk = ~clk;

  encoder4to2_rr #(.ROTATE(1), .CNT_W(8)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in0_i(in0), .in1_i(in1), .in2_i(in2),
    .in3_i(in3), .ready_i(rdy0), .a_o(a0), .b_o(b0), .valid_o(v0), .multi_o(m0), .cnt_o(c0)
  );

  encoder4to2_rr #(.ROTATE(0), .CNT_W(8)) u_fx (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in0_i(in0), .in1_i(in1), .in2_i(in2),
    .in3_i(in3), .ready_i(rdy1), .a_o(a1), .b_o(b1), .valid_o(v1), .multi_o(m1), .cnt_o(c1)
  );

  encoder4to2_rr #(.ROTATE(1), .CNT_W(2)) u_wr (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .in0_i(in0), .in1_i(in1), .in2_i(in2),
    .in3_i(in3), .ready_i(rdy2), .a_o(a2), .b_o(b2), .valid_o(v2), .multi_o(m2), .cnt_o(c2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepted transfer: valid&ready out of reset at the coming edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && v0 === 1'b1 && rdy0 === 1'b1) begin
      if (q0.size() == 0) check("rr_unexpected_xfer", {29'd0, a0, b0, m0}, 32'hFFFF_FFFF);
      else check("rr_xfer", {29'd0, a0, b0, m0}, {29'd0, q0.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && v1 === 1'b1 && rdy1 === 1'b1) begin
      if (q1.size() == 0) check("fx_unexpected_xfer", {29'd0, a1, b1, m1}, 32'hFFFF_FFFF);
      else check("fx_xfer", {29'd0, a1, b1, m1}, {29'd0, q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && v2 === 1'b1 && rdy2 === 1'b1) begin
      if (q2.size() == 0) check("wr_unexpected_xfer", {29'd0, a2, b2, m2}, 32'hFFFF_FFFF);
      else check("wr_xfer", {29'd0, a2, b2, m2}, {29'd0, q2.pop_front()});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {in3, in2, in1, in0} = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    en = 1'b0;
    set_req(4'b0000);
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; set_req(4'b0000);
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom);
      set_req(4'($urandom));
      rdy0 = 1'($urandom); rdy1 = 1'($urandom); rdy2 = 1'($urandom);
      step(1);
    end
    check("rst_valid", {31'd0, v0}, 32'd0);
    check("rst_ab", {30'd0, a0, b0}, 32'd0);
    check("rst_multi", {31'd0, m0}, 32'd0);
    check("rst_cnt", {24'd0, c0}, 32'd0);
    check("rst_fx_valid", {31'd0, v1}, 32'd0);
    check("rst_wr_cnt", {30'd0, c2}, 32'd0);

    // Release with in2 -> 10 one edge later
    rst_n = 1'b1; en = 1'b1; set_req(4'b0100);
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
    step(1);
    check("rel_valid", {31'd0, v0}, 32'd1);
    check("rel_ab", {30'd0, a0, b0}, 32'd2);
    check("rel_multi", {31'd0, m0}, 32'd0);

    // Hold until ready
    do_reset();
    en = 1'b1; set_req(4'b0010);
    step(1);
    q0.push_back(3'b01_0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) set_req(4'b1000);
      step(1);
      check("hold_valid", {31'd0, v0}, 32'd1);
      check("hold_ab", {30'd0, a0, b0}, 32'd1);
    end
    rdy0 = 1'b1;
    step(1);
    rdy0 = 1'b0;
    check("hs_cnt", {24'd0, c0}, 32'd1);
    check("hs_ab_recapture", {30'd0, a0, b0}, 32'd3);
    check("hs_valid", {31'd0, v0}, 32'd1);
    q0.push_back(3'b11_0);
    set_req(4'b0000);
    rdy0 = 1'b1;
    step(1);
    rdy0 = 1'b0;
    check("drain_valid", {31'd0, v0}, 32'd0);
    check("drain_cnt", {24'd0, c0}, 32'd2);
    // IDLE with ready high: no count, outputs keep last values
    rdy0 = 1'b1;
    step(2);
    rdy0 = 1'b0;
    check("idle_cnt", {24'd0, c0}, 32'd2);
    check("idle_ab_kept", {30'd0, a0, b0}, 32'd3);

    // Round-robin with all lines high
    do_reset();
    en = 1'b1; set_req(4'b1111); rdy0 = 1'b1;
    q0.push_back(3'b00_1); q0.push_back(3'b01_1); q0.push_back(3'b10_1);
    q0.push_back(3'b11_1); q0.push_back(3'b00_1); q0.push_back(3'b01_1);
    step(7);
    rdy0 = 1'b0;
    check("rr_cnt", {24'd0, c0}, 32'd6);
    check("rr_next_ab", {30'd0, a0, b0}, 32'd2);
    check("rr_next_multi", {31'd0, m0}, 32'd1);

    // Fixed priority on u_fx
    do_reset();
    en = 1'b1; set_req(4'b1010); rdy1 = 1'b1;
    q1.push_back(3'b01_1); q1.push_back(3'b01_1); q1.push_back(3'b01_1);
    q1.push_back(3'b11_0);
    step(3);
    set_req(4'b1000);
    step(1);
    check("fx_single_ab", {30'd0, a1, b1}, 32'd3);
    check("fx_single_multi", {31'd0, m1}, 32'd0);
    set_req(4'b0000);
    step(1);
    rdy1 = 1'b0;
    check("fx_cnt", {24'd0, c1}, 32'd4);
    check("fx_idle", {31'd0, v1}, 32'd0);

    // Enable gating, then reset during HOLD with ready high
    do_reset();
    en = 1'b0; set_req(4'b0001);
    step(3);
    check("en_gate_valid", {31'd0, v0}, 32'd0);
    en = 1'b1;
    step(1);
    check("en_cap_valid", {31'd0, v0}, 32'd1);
    check("en_cap_ab", {30'd0, a0, b0}, 32'd0);
    rst_n = 1'b0; rdy0 = 1'b1;
    step(1);
    check("rst_hold_valid", {31'd0, v0}, 32'd0);
    check("rst_hold_cnt", {24'd0, c0}, 32'd0);
    rst_n = 1'b1; rdy0 = 1'b0; set_req(4'b0000);

    // Counter wrap on u_wr
    do_reset();
    en = 1'b1; set_req(4'b0100);
    step(1);
    rdy2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      automatic logic [1:0] exp_c = 2'(i + 1);
      q2.push_back(3'b10_0);
      step(1);
      check("wrap_cnt", {30'd0, c2}, {30'd0, exp_c});
    end
    rdy2 = 1'b0;
    step(1);

    check("q_rr_empty", q0.size(), 32'd0);
    check("q_fx_empty", q1.size(), 32'd0);
    check("q_wr_empty", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder4to2_rr.md
# encoder4to2_rr

Registered 4:2 encoder with round-robin priority and a valid/ready output handshake. It is the inverse of the team's 2:4 decoder. It samples four request lines, selects one, and presents the selected index as `{a,b}`, with `a` as MSB. The result is held until downstream accepts it, so a decoder driven by `{a,b}` regenerates the one-hot line. It sits between request sources and the decoder/select logic, and also flags multi-hot inputs and counts completed transfers.

## Interface
- `ROTATE`, default 1: 1 selects round-robin priority; 0 selects fixed priority with in0 highest and in3 lowest.
- `CNT_W`, default 8: width of the transfer counter `cnt`.

- `clk`  in  1  sole clock; everything updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `en`  in  1  capture enable; no new capture occurs while `en`=0.
- `in0`, `in1`, `in2`, `in3`  in  1 each  request lines, level-sensitive.
- `ready`  in  1  downstream accept.
- `a`, `b`  out  1 each  encoded index of the selected request. `{a,b}`=00 means in0 and 11 means in3.
- `valid`  out  1  `{a,b}` and `multi` are valid.
- `multi`  out  1  two or more request lines were high at the capturing edge.
- `cnt`  out  `CNT_W`  number of completed handshakes; wraps modulo 2^`CNT_W`.

## Operation
- The block has two states:
  - IDLE: `valid`=0.
  - HOLD: `valid`=1; `a`, `b` and `multi` are frozen.
- An internal 2-bit priority pointer `ptr` names the highest-priority line.
- Search order from `ptr`: `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4. The first line that is high wins.
- **Capture condition:** `en`=1 and at least one `inN`=1, evaluated at the edge.
- **Capture action:**
  - Load the winner's index into `{a,b}`.
  - Set `multi` = (popcount of in0..in3 ≥ 2).
  - Enter HOLD.
  - If `ROTATE`=1, set `ptr` = winner+1 mod 4, so index 3 wraps to 0. If `ROTATE`=0, `ptr` stays 0.
- **IDLE:**
  - Capture condition true → capture action.
  - Otherwise stay in IDLE; `a`, `b` and `multi` keep their last values.
- **HOLD:**
  - Request and `en` changes are ignored while `ready`=0.
  - Handshake = `valid`&`ready` at the edge; each handshake increments `cnt` by 1.
  - Handshake and capture condition both true → capture the new request and stay in HOLD. This gives back-to-back transfers with `valid` held at 1.
  - Handshake with capture condition false → go to IDLE with `valid`=0.
- **Single requester:** with only one line high, that line always wins regardless of `ptr`.
- **Starvation freedom:** with `ROTATE`=1 and all four lines held high, the grant sequence cycles 0, 1, 2, 3, 0, …

## Timing
- **Reset:** `rst_n`=0 at an edge sets:
  - state = IDLE, `valid`=0;
  - `a`=0, `b`=0, `multi`=0;
  - `ptr`=0, `cnt`=0.
- **Reset during HOLD:** the pending transfer is discarded and not counted, even if `ready`=1 at that edge.
- **Capture latency:** a request sampled at edge k shows `valid`=1 with `{a,b}` from edge k onward, i.e. one cycle of latency.
- **Release latency:** a handshake at edge k leaves `valid`=0 after k when there is no new capture. `cnt` updates at edge k.
- **Throughput:** one transfer per cycle when `ready` is held at 1 and requests are present.
- **Output stability:** `a`, `b` and `multi` change only on a capture edge or on reset.
- **`ready` outside HOLD:** `ready` is don't-care in IDLE; it has no effect and `cnt` does not change.
- **Counter wrap:** `cnt` wraps from 2^`CNT_W`−1 to 0 with no flag.

## Test plan
- **Reset values:** `rst_n`=0 for 2 cycles with random inputs → `valid`=0, `a`=`b`=0, `multi`=0, `cnt`=0. Release with `en`=1, in2=1 → one edge later `valid`=1, `{a,b}`=10, `multi`=0.
- **Hold until ready:** in1=1 with `ready`=0 for 5 cycles, in1 dropped and in3 raised meanwhile → `{a,b}` stays 01 and `valid` stays 1. Then `ready`=1 for one edge → `cnt`=1 and `{a,b}`=11 (in3 captured on the handshake edge).
- **Round-robin rotation:** `ROTATE`=1, all four lines high, `en`=1, `ready`=1 for 6 cycles → `{a,b}` sequence 00, 01, 10, 11, 00, 01; `multi`=1 throughout; `cnt`=6.
- **Fixed priority:** `ROTATE`=0, in1 and in3 high, `ready`=1 for 3 cycles → `{a,b}`=01 every cycle and `multi`=1. Then only in3 high → 11 with `multi`=0.
- **Enable gating and reset mid-transfer:** `en`=0 with in0=1 → `valid` stays 0. Then `en`=1 → capture of 00. `rst_n`=0 while in HOLD with `ready`=1 → `valid`=0 and `cnt` unchanged at 0.
- **Counter wrap:** `CNT_W`=2, 5 consecutive handshakes → `cnt` reads 1, 2, 3, 0, 1.
